// File: rtl/fp_wrb_arbiter_if.sv
// Bundle of the requester-side handshakes and the regfile write ports of the
// floating-point writeback arbiter. Flat vectors pack one slice per requester
// or per port, with index 0 in the least significant slice.
//
// Handshake rule: a requester transfers on a rising edge where
// req_valid_i[i] & req_ready_o[i] are both high; while waiting it must hold
// valid, addr and data stable.
interface fp_wrb_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_PORT       = 2,
    parameter int REG_SIZE_WIDTH = 7,
    parameter int XLEN           = 64
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ*REG_SIZE_WIDTH-1:0]  req_addr_i;
    logic [NUM_REQ*XLEN-1:0]            req_data_i;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic                               wrb_stall_i;
    logic [NUM_PORT-1:0]                wr_valid_o;
    logic [NUM_PORT*REG_SIZE_WIDTH-1:0] wr_addr_o;
    logic [NUM_PORT*XLEN-1:0]           wr_data_o;
    logic [PTR_W-1:0]                   rr_ptr_o;

    // Producers and regfile side (the environment around the arbiter).
    modport master (
        output req_valid_i, req_addr_i, req_data_i, wrb_stall_i,
        input  req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, rr_ptr_o
    );

    // The arbiter itself.
    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, wrb_stall_i,
        output req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, rr_ptr_o
    );
endinterface

// File: rtl/fp_wrb_arbiter.sv
// Floating-point writeback arbiter: picks up to two of the requesters
// (falu1, falu2, lsu, fdivsqrt) per cycle under rotating priority and drives
// two registered regfile write ports. Two candidates hitting the same nonzero
// register are serialised; writes to p0 are accepted but never issued.
module fp_wrb_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_PORT       = 2,
    parameter int REG_SIZE_WIDTH = 7,
    parameter int XLEN           = 64
) (
    input logic            clk,
    input logic            rst_n,
    fp_wrb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]                   rr_ptr;
    logic [PTR_W-1:0]                   ptr_next;
    logic [PTR_W-1:0]                   scan_idx;
    logic [PTR_W-1:0]                   idx0;
    logic [PTR_W-1:0]                   idx1;
    logic                               found0;
    logic                               found1;
    logic                               grant_allowed;
    logic                               addr_conflict;
    logic                               grant0;
    logic                               grant1;
    logic [REG_SIZE_WIDTH-1:0]          addr0;
    logic [REG_SIZE_WIDTH-1:0]          addr1;
    logic [XLEN-1:0]                    data0;
    logic [XLEN-1:0]                    data1;
    logic [NUM_REQ-1:0]                 ready;
    logic [NUM_PORT-1:0]                wr_valid_q;
    logic [NUM_PORT*REG_SIZE_WIDTH-1:0] wr_addr_q;
    logic [NUM_PORT*XLEN-1:0]           wr_data_q;

    // Circular scan from rr_ptr: first and second valid requesters.
    always_comb begin
        found0   = 1'b0;
        found1   = 1'b0;
        idx0     = '0;
        idx1     = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (bus.req_valid_i[scan_idx]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    idx0   = scan_idx;
                end else if (!found1) begin
                    found1 = 1'b1;
                    idx1   = scan_idx;
                end
            end
        end
    end

    // Grant decision, ready vector and next pointer.
    always_comb begin
        addr0         = bus.req_addr_i[idx0*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
        addr1         = bus.req_addr_i[idx1*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
        data0         = bus.req_data_i[idx0*XLEN +: XLEN];
        data1         = bus.req_data_i[idx1*XLEN +: XLEN];
        // Same nonzero destination: the second candidate waits and, because
        // the pointer lands just after the first, leads the next scan.
        addr_conflict = (addr0 == addr1) && (addr0 != '0);
        grant_allowed = rst_n && !bus.wrb_stall_i;
        grant0        = found0 && grant_allowed;
        grant1        = found1 && grant_allowed && !addr_conflict;
        ready         = '0;
        if (grant0) ready[idx0] = 1'b1;
        if (grant1) ready[idx1] = 1'b1;
        ptr_next = rr_ptr;
        if (grant1) begin
            ptr_next = PTR_W'((int'(idx1) + 1) % NUM_REQ);
        end else if (grant0) begin
            ptr_next = PTR_W'((int'(idx0) + 1) % NUM_REQ);
        end
    end

    // Pointer and write-port registers; addr/data hold when not granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            wr_valid_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rr_ptr        <= ptr_next;
            wr_valid_q[0] <= grant0 && (addr0 != '0);
            wr_valid_q[1] <= grant1 && (addr1 != '0);
            if (grant0) begin
                wr_addr_q[0 +: REG_SIZE_WIDTH] <= addr0;
                wr_data_q[0 +: XLEN]           <= data0;
            end
            if (grant1) begin
                wr_addr_q[REG_SIZE_WIDTH +: REG_SIZE_WIDTH] <= addr1;
                wr_data_q[XLEN +: XLEN]                     <= data1;
            end
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.wr_valid_o  = wr_valid_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.rr_ptr_o    = rr_ptr;
endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// Bench for fp_wrb_arbiter: directed scenarios with literal expectations,
// then constrained-random traffic, all compared every cycle against a
// queue-based model of the arbitration rules.
module tb_fp_wrb_arbiter;
    logic clk;
    logic rst_n;

    fp_wrb_arbiter_if bus ();

    fp_wrb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks;
    int errors;

    // requester-side stimulus state
    logic [3:0]  r_valid;
    logic [6:0]  r_addr[4];
    logic [63:0] r_data[4];
    logic        r_stall;

    // model state
    int          m_ptr;
    logic [1:0]  m_wv;
    logic [6:0]  m_wa[2];
    logic [63:0] m_wd[2];
    logic [3:0]  exp_ready;
    logic        g_ok[2];
    int          g_idx[2];
    logic [3:0]  last_ready;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        bus.req_valid_i = r_valid;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr_i[i*7 +: 7]  = r_addr[i];
            bus.req_data_i[i*64 +: 64] = r_data[i];
        end
        bus.wrb_stall_i = r_stall;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_wv  = '0;
        for (int p = 0; p < 2; p++) begin
            m_wa[p] = '0;
            m_wd[p] = '0;
        end
    endtask

    // Rules: list valid requesters in circular order from the pointer,
    // take the first two, drop the second on a nonzero address clash.
    task automatic model_eval();
        int q[$];
        q = {};
        exp_ready = '0;
        g_ok[0] = 1'b0;
        g_ok[1] = 1'b0;
        g_idx[0] = 0;
        g_idx[1] = 0;
        for (int k = 0; k < 4; k++) begin
            if (r_valid[(m_ptr + k) % 4]) q.push_back((m_ptr + k) % 4);
        end
        if (rst_n && !r_stall) begin
            if (q.size() >= 1) begin
                g_ok[0]  = 1'b1;
                g_idx[0] = q[0];
            end
            if (q.size() >= 2) begin
                if (!(r_addr[q[0]] == r_addr[q[1]] && r_addr[q[0]] != 0)) begin
                    g_ok[1]  = 1'b1;
                    g_idx[1] = q[1];
                end
            end
        end
        for (int p = 0; p < 2; p++) if (g_ok[p]) exp_ready[g_idx[p]] = 1'b1;
    endtask

    task automatic model_update();
        for (int p = 0; p < 2; p++) begin
            m_wv[p] = g_ok[p] && (r_addr[g_idx[p]] != 0);
            if (g_ok[p]) begin
                m_wa[p] = r_addr[g_idx[p]];
                m_wd[p] = r_data[g_idx[p]];
            end
        end
        if (g_ok[1])      m_ptr = (g_idx[1] + 1) % 4;
        else if (g_ok[0]) m_ptr = (g_idx[0] + 1) % 4;
    endtask

    // Compare all DUT outputs to the model, clock once, retire accepted requests.
    task automatic run_cycle();
        #1;
        model_eval();
        chk("ready",    64'(bus.req_ready_o), 64'(exp_ready));
        chk("rr_ptr",   64'(bus.rr_ptr_o),    64'(m_ptr));
        chk("wr_valid", 64'(bus.wr_valid_o),  64'(m_wv));
        chk("wr_addr0", 64'(bus.wr_addr_o[6:0]),   64'(m_wa[0]));
        chk("wr_addr1", 64'(bus.wr_addr_o[13:7]),  64'(m_wa[1]));
        chk("wr_data0", bus.wr_data_o[63:0],       m_wd[0]);
        chk("wr_data1", bus.wr_data_o[127:64],     m_wd[1]);
        last_ready = bus.req_ready_o;
        @(posedge clk);
        model_update();
        #1;
        r_valid = r_valid & ~last_ready;
        apply();
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [63:0] d);
        r_valid[i] = 1'b1;
        r_addr[i]  = a;
        r_data[i]  = d;
    endtask

    initial begin
        int waited;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        r_valid = '0;
        r_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_addr[i] = '0;
            r_data[i] = '0;
        end
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_valid", 64'(bus.wr_valid_o), 64'h0);
        chk("rst_ptr",      64'(bus.rr_ptr_o),   64'h0);

        // all four valid, distinct addresses; first edge after reset grants 0,1
        for (int i = 0; i < 4; i++) set_req(i, 7'(10 + i), 64'(10 + i));
        apply();
        rst_n = 1'b1;
        run_cycle();
        chk("lit_ready_c0", 64'(last_ready),          64'h3);
        chk("lit_ptr_c0",   64'(bus.rr_ptr_o),        64'h2);
        chk("lit_wv_c0",    64'(bus.wr_valid_o),      64'h3);
        chk("lit_wa_c0",    64'(bus.wr_addr_o),       64'({7'd11, 7'd10}));
        chk("lit_wd0_c0",   bus.wr_data_o[63:0],      64'hA);
        chk("lit_wd1_c0",   bus.wr_data_o[127:64],    64'hB);
        run_cycle();
        chk("lit_ready_c1", 64'(last_ready),          64'hC);
        chk("lit_ptr_c1",   64'(bus.rr_ptr_o),        64'h0);
        chk("lit_wa_c1",    64'(bus.wr_addr_o),       64'({7'd13, 7'd12}));
        chk("lit_wd0_c1",   bus.wr_data_o[63:0],      64'hC);
        chk("lit_wd1_c1",   bus.wr_data_o[127:64],    64'hD);

        // move pointer to 1, then same-address conflict between req1 and req2
        set_req(0, 7'd5, 64'h55);
        apply();
        run_cycle();
        chk("lit_ptr_to1", 64'(bus.rr_ptr_o), 64'h1);
        set_req(1, 7'd20, 64'h1111);
        set_req(2, 7'd20, 64'h2222);
        apply();
        run_cycle();
        chk("lit_conf_ready", 64'(last_ready),      64'h2);
        chk("lit_conf_wv",    64'(bus.wr_valid_o),  64'h1);
        chk("lit_conf_ptr",   64'(bus.rr_ptr_o),    64'h2);
        run_cycle();
        chk("lit_conf2_ready", 64'(last_ready),         64'h4);
        chk("lit_conf2_wd0",   bus.wr_data_o[63:0],     64'h2222);
        chk("lit_conf2_ptr",   64'(bus.rr_ptr_o),       64'h3);

        // write to p0: accepted but never issued
        set_req(3, 7'd0, 64'hFFFF);
        apply();
        run_cycle();
        chk("lit_p0_ready", 64'(last_ready),     64'h8);
        chk("lit_p0_wv",    64'(bus.wr_valid_o), 64'h0);
        chk("lit_p0_ptr",   64'(bus.rr_ptr_o),   64'h0);

        // stall for three cycles with everyone valid
        for (int i = 0; i < 4; i++) set_req(i, 7'(50 + i), 64'(16'hBE00 + i));
        r_stall = 1'b1;
        apply();
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            chk("lit_stall_ready", 64'(last_ready),     64'h0);
            chk("lit_stall_wv",    64'(bus.wr_valid_o), 64'h0);
            chk("lit_stall_ptr",   64'(bus.rr_ptr_o),   64'h0);
        end
        r_stall = 1'b0;
        apply();
        run_cycle();
        chk("lit_unstall_ready", 64'(last_ready), 64'h3);

        // fairness: req0 continuously busy, req3 joins later
        r_valid = '0;
        apply();
        for (int c = 0; c < 5; c++) begin
            set_req(0, 7'(40 + c), 64'(c));
            apply();
            run_cycle();
        end
        set_req(0, 7'd45, 64'h45);
        set_req(3, 7'd30, 64'h30);
        apply();
        waited = 0;
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            if (last_ready[3]) break;
            waited++;
            set_req(0, 7'(46 + c), 64'(c));
            apply();
        end
        chk("lit_fair_wait", 64'(waited <= 1), 64'h1);

        // randomized traffic under the handshake rules
        r_valid = '0;
        apply();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r_valid[i] && $urandom_range(0, 99) < 60)
                    set_req(i, 7'($urandom_range(0, 7)), {$urandom, $urandom});
            end
            r_stall = ($urandom_range(0, 99) < 15);
            apply();
            run_cycle();
        end

        // asynchronous reset in the middle of a cycle with all valids high
        for (int i = 0; i < 4; i++) set_req(i, 7'(60 + i), 64'(i + 1));
        r_stall = 1'b0;
        apply();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(bus.req_ready_o), 64'h0);
        chk("async_rst_wv",    64'(bus.wr_valid_o),  64'h0);
        chk("async_rst_ptr",   64'(bus.rr_ptr_o),    64'h0);
        chk("async_rst_wa",    64'(bus.wr_addr_o),   64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle();
        chk("lit_after_rst_ready", 64'(last_ready),   64'h3);
        chk("lit_after_rst_wa",    64'(bus.wr_addr_o), 64'({7'd61, 7'd60}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
